// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, DMA and dmem port signals around dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_dout;

    logic              dma_req;
    logic [3:0]        dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_dout;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  dma_req, dma_we, dma_addr, dma_din,
        input  mem_dout,
        output cpu_stall, cpu_rvalid, cpu_dout,
        output dma_gnt, dma_rvalid, dma_dout,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output dma_req, dma_we, dma_addr, dma_din,
        output mem_dout,
        input  cpu_stall, cpu_rvalid, cpu_dout,
        input  dma_gnt, dma_rvalid, dma_dout,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single dmem port between the CPU MEM stage and a DMA master, CPU first.
// Define DMEM_ARB_STARVE_GUARD_EN to force a DMA grant after STARVE_LIMIT denied cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   force_dma;
    logic   cpu_win;
    logic   dma_win;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_dma = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        // NOTE: default first so no path through this block leaves starve_d unassigned (no latch).
        starve_d = starve_q;
        if (!bus.dma_req || dma_win) begin
            starve_d = '0;
        end else if (!force_dma) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    // Grants are masked while rst is high so nothing reaches dmem during reset.
    always_comb begin
        cpu_win = !rst && bus.cpu_req && !(force_dma && bus.dma_req);
        dma_win = !rst && bus.dma_req && (!bus.cpu_req || force_dma);
    end

    always_comb begin
        bus.cpu_stall = !rst && bus.cpu_req && !cpu_win;
        bus.dma_gnt   = dma_win;
        bus.mem_en    = cpu_win || dma_win;
        bus.mem_we    = 4'h0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_din   = bus.cpu_din;
        if (dma_win) begin
            bus.mem_we   = bus.dma_we;
            bus.mem_addr = bus.dma_addr;
            bus.mem_din  = bus.dma_din;
        end else if (cpu_win) begin
            bus.mem_we = bus.cpu_we;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_win && bus.cpu_we == 4'h0) begin
            owner_d = OWN_CPU;
        end else if (dma_win && bus.dma_we == 4'h0) begin
            owner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so every register samples pre-edge values.
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // rvalid is also masked by rst so a read accepted just before reset is dropped at once.
    always_comb begin
        bus.cpu_rvalid = !rst && (owner_q == OWN_CPU);
        bus.dma_rvalid = !rst && (owner_q == OWN_DMA);
        bus.cpu_dout   = bus.mem_dout;
        bus.dma_dout   = bus.mem_dout;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter; follows DMEM_ARB_STARVE_GUARD_EN
// to pick the expected arbitration under continuous contention.
module tb_dmem_port_arbiter;
    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked after settling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_forced;
        logic forced;
        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 4'h0;
        bus.cpu_addr = 14'h010;
        bus.cpu_din  = 32'h0;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 4'h0;
        bus.dma_addr = 14'h000;
        bus.dma_din  = 32'h0;
        bus.mem_dout = 32'h0;
        step();
        step();
        check("rst_cpu_stall", bus.cpu_stall, 1'b0);
        check("rst_dma_gnt", bus.dma_gnt, 1'b0);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_mem_we", bus.mem_we, 4'h0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_dma_rvalid", bus.dma_rvalid, 1'b0);

        // CPU read of 0x010
        rst         = 1'b0;
        bus.dma_req = 1'b0;
        #1;
        check("cpu_rd_mem_en", bus.mem_en, 1'b1);
        check("cpu_rd_stall", bus.cpu_stall, 1'b0);
        check("cpu_rd_mem_addr", 32'(bus.mem_addr), 32'h010);
        check("cpu_rd_mem_we", bus.mem_we, 4'h0);
        step();
        bus.cpu_req  = 1'b0;
        bus.mem_dout = 32'hDEADBEEF;
        #1;
        check("cpu_rd_rvalid", bus.cpu_rvalid, 1'b1);
        check("cpu_rd_dout", bus.cpu_dout, 32'hDEADBEEF);
        check("cpu_rd_dma_rvalid", bus.dma_rvalid, 1'b0);

        // DMA-only write
        bus.dma_req  = 1'b1;
        bus.dma_we   = 4'hF;
        bus.dma_addr = 14'h020;
        bus.dma_din  = 32'h12345678;
        #1;
        check("dma_wr_gnt", bus.dma_gnt, 1'b1);
        check("dma_wr_mem_en", bus.mem_en, 1'b1);
        check("dma_wr_mem_we", bus.mem_we, 4'hF);
        check("dma_wr_mem_addr", 32'(bus.mem_addr), 32'h020);
        check("dma_wr_mem_din", bus.mem_din, 32'h12345678);
        step();
        bus.dma_req = 1'b0;
        #1;
        check("dma_wr_no_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("dma_wr_no_dma_rvalid", bus.dma_rvalid, 1'b0);

        // Continuous contention: both read every cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 4'h0;
        bus.cpu_addr = 14'h030;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 4'h0;
        bus.dma_addr = 14'h040;
        prev_forced  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            forced = GUARD && (i == STARVE_LIMIT);
            check($sformatf("both_gnt_%0d", i), bus.dma_gnt, forced);
            check($sformatf("both_stall_%0d", i), bus.cpu_stall, forced);
            check($sformatf("both_addr_%0d", i), 32'(bus.mem_addr), forced ? 32'h040 : 32'h030);
            if (i > 0) begin
                check($sformatf("both_cpu_rvalid_%0d", i), bus.cpu_rvalid, !prev_forced);
                check($sformatf("both_dma_rvalid_%0d", i), bus.dma_rvalid, prev_forced);
            end
            prev_forced = forced;
            step();
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        step();

        // Reset right after an accepted CPU read drops the pending rvalid
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 14'h050;
        #1;
        check("rstmid_mem_en", bus.mem_en, 1'b1);
        step();
        bus.cpu_req = 1'b0;
        rst         = 1'b1;
        #1;
        check("rstmid_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rstmid_mem_en_off", bus.mem_en, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rstmid_after_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rstmid_after_dma_rvalid", bus.dma_rvalid, 1'b0);

        // CPU write, DMA read, CPU read with no overlap
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 4'h3;
        bus.cpu_addr = 14'h060;
        bus.cpu_din  = 32'hCAFE0001;
        #1;
        check("alt_cpu_wr_stall", bus.cpu_stall, 1'b0);
        check("alt_cpu_wr_mem_we", bus.mem_we, 4'h3);
        check("alt_cpu_wr_mem_din", bus.mem_din, 32'hCAFE0001);
        step();
        bus.cpu_req  = 1'b0;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 4'h0;
        bus.dma_addr = 14'h070;
        #1;
        check("alt_wr_no_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("alt_wr_no_dma_rvalid", bus.dma_rvalid, 1'b0);
        check("alt_dma_rd_gnt", bus.dma_gnt, 1'b1);
        check("alt_dma_rd_addr", 32'(bus.mem_addr), 32'h070);
        step();
        bus.dma_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 4'h0;
        bus.cpu_addr = 14'h080;
        bus.mem_dout = 32'hA5A50001;
        #1;
        check("alt_dma_rvalid", bus.dma_rvalid, 1'b1);
        check("alt_dma_dout", bus.dma_dout, 32'hA5A50001);
        check("alt_dma_no_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("alt_cpu_rd_stall", bus.cpu_stall, 1'b0);
        step();
        bus.cpu_req  = 1'b0;
        bus.mem_dout = 32'hA5A50002;
        #1;
        check("alt_cpu_rvalid", bus.cpu_rvalid, 1'b1);
        check("alt_cpu_dout", bus.cpu_dout, 32'hA5A50002);
        check("alt_cpu_no_dma_rvalid", bus.dma_rvalid, 1'b0);
        step();
        check("idle_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("idle_mem_en", bus.mem_en, 1'b0);
        check("idle_mem_we", bus.mem_we, 4'h0);
        check("idle_mem_addr", 32'(bus.mem_addr), 32'h080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter for the single-port data memory (`dmem`) used by the Riscv151 MEM stage. It shares the port between the CPU load/store path and a second bus master (DMA / bulk loader). Each cycle it picks one requester, drives the memory port from the winner, and stalls the CPU when it loses. Read data is steered back with a registered one-cycle valid, which matches the synchronous read latency of `dmem`.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width (matches `dmem` addr, byte address [15:2])
- `DATA_W`, 32: data width
- `STARVE_LIMIT`, 8: number of consecutive denied DMA cycles before DMA is forced through (only used with the starvation guard)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `cpu_req`  in  1  CPU access request (MEM stage)
- `cpu_we`  in  4  CPU byte write enables; 0 = read
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_din`  in  DATA_W  CPU write data
- `cpu_stall`  out  1  CPU request not accepted this cycle
- `cpu_rvalid`  out  1  CPU read data valid on `cpu_dout`
- `cpu_dout`  out  DATA_W  read data to CPU
- `dma_req`  in  1  DMA access request
- `dma_we`  in  4  DMA byte write enables; 0 = read
- `dma_addr`  in  ADDR_W  DMA word address
- `dma_din`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA request accepted this cycle
- `dma_rvalid`  out  1  DMA read data valid on `dma_dout`
- `dma_dout`  out  DATA_W  read data to DMA
- `mem_en`  out  1  dmem enable
- `mem_we`  out  4  dmem byte write enables
- `mem_addr`  out  ADDR_W  dmem address
- `mem_din`  out  DATA_W  dmem write data
- `mem_dout`  in  DATA_W  dmem read data (synchronous, 1-cycle)

## Operation
- Handshake: a requester holds req/we/addr/din stable until accepted. A request is accepted at the posedge where it is granted. For the CPU, "granted" means `cpu_req & ~cpu_stall`. For the DMA it means `dma_gnt`.
- Grant decision is combinational in the current cycle:
  - Only one requester active: it wins.
  - Both active: the CPU wins. The exception is a forced DMA cycle (see Configuration).
  - Neither active: `mem_en=0`, `mem_we=0`.
- `mem_en/we/addr/din` are muxed from the winner. `mem_addr`/`mem_din` hold the CPU fields when idle.
- `cpu_stall = cpu_req & ~cpu_win`. `dma_gnt = dma_req & dma_win`.
- Read tracking: on an accepted read (we==0), the owner register is loaded with CPU or DMA. On an accepted write or no access it is loaded with NONE.
  - The next cycle, the owner's rvalid is 1.
  - `cpu_dout` and `dma_dout` both pass `mem_dout` straight through. Consumers qualify the data with rvalid.
- Writes produce no rvalid. Back-to-back accepted reads yield rvalid on consecutive cycles.
- Reset (including mid-transaction): owner=NONE, starvation counter=0, and a pending rvalid is dropped. Outputs during reset:
  - `cpu_rvalid=0`, `dma_rvalid=0`, `mem_en=0`, `mem_we=0`, `dma_gnt=0`
  - `cpu_stall=0`, even if `cpu_req` is high

## Timing
- Request to memory: 0 cycles (combinational). dmem samples at the same posedge as acceptance.
- Accepted read to rvalid: 1 cycle, registered.
- Combinational paths: req→stall/gnt, and req→mem_*.
- Worst-case CPU stall: 1 cycle per forced DMA grant. Without the guard the CPU is never stalled.
- Worst-case DMA wait: unbounded without the guard, `STARVE_LIMIT`+1 cycles with it.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - A counter (width `$clog2(STARVE_LIMIT+1)`) increments each cycle `dma_req & ~dma_gnt`.
  - It clears on `dma_gnt` or when `dma_req=0`, and saturates at `STARVE_LIMIT`.
  - While count==`STARVE_LIMIT`, a conflict cycle is granted to the DMA and `cpu_stall=1`.
- Not defined: strict CPU priority, no counter logic is built, and `cpu_stall` is tied to 0.

## Test plan
- Reset, then CPU read addr 0x010 with `mem_dout`=0xDEADBEEF → `mem_en=1`, `cpu_stall=0`; next cycle `cpu_rvalid=1`, `cpu_dout`=0xDEADBEEF, `dma_rvalid=0`.
- DMA-only write `dma_we`=4'hF, addr 0x020, data 0x12345678 → `dma_gnt=1`, mem_* carry the DMA fields, no rvalid next cycle.
- Both request reads continuously, guard off → CPU granted every cycle, `dma_gnt=0` throughout, `cpu_stall=0`.
- Same stimulus with guard on, `STARVE_LIMIT`=8:
  - `dma_gnt=1` and `cpu_stall=1` on the 9th cycle, with `dma_rvalid=1` the following cycle.
  - Counter is back to 0 and the CPU wins the next cycle.
- CPU read accepted, `rst`=1 on the next cycle → `cpu_rvalid=0`, `mem_en=0`, owner NONE. After reset is released, no spurious rvalid.
- Alternate CPU write / DMA read / CPU read with no overlap → each access is granted immediately, and rvalid is asserted only for the read owners, in order.
